// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the classifier output stage.
package nn_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned SCORE_W     = 26;
  localparam int unsigned ACT_W       = 13;
  localparam int unsigned WGT_W       = 13;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/output_score_accumulator_mac_lane.sv
// One class lane: signed multiply-accumulate, bias add and output saturation.
module mac_lane #(
  parameter int unsigned ACT_W   = nn_pkg::ACT_W,
  parameter int unsigned WGT_W   = nn_pkg::WGT_W,
  parameter int unsigned SCORE_W = nn_pkg::SCORE_W,
  parameter int unsigned ACC_W   = 36
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      en_mul,
  input  logic                      en_bias,
  input  logic signed [ACT_W-1:0]   a,
  input  logic signed [WGT_W-1:0]   w,
  input  logic signed [SCORE_W-1:0] b,
  output logic [SCORE_W-1:0]        score
);

  localparam int unsigned PROD_W = ACT_W + WGT_W;
  localparam int unsigned TOP_W  = ACC_W - SCORE_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         acc_d;
  logic [ACC_W-1:0]         acc_q;
  logic [TOP_W-1:0]         acc_top;

  // Full-precision product and next accumulator value
  always_comb begin
    prod  = a * w;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en_mul) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end else if (en_bias) begin
      acc_d = acc_q + {{(ACC_W-SCORE_W){b[SCORE_W-1]}}, b};
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // The value fits in SCORE_W bits exactly when all bits above the score sign bit agree with it
  always_comb begin
    acc_top = acc_q[ACC_W-1:SCORE_W-1];
    if (acc_top == '0 || acc_top == '1) begin
      score = acc_q[SCORE_W-1:0];
    end else if (acc_q[ACC_W-1]) begin
      score = {1'b1, {(SCORE_W-1){1'b0}}};
    end else begin
      score = {1'b0, {(SCORE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/output_score_accumulator.sv
// Final dense layer: serial activations x per-class weights, bias, saturated packed scores.
module output_score_accumulator #(
  parameter int unsigned NUM_INPUTS  = 64,
  parameter int unsigned ACT_W       = nn_pkg::ACT_W,
  parameter int unsigned WGT_W       = nn_pkg::WGT_W,
  parameter int unsigned SCORE_W     = nn_pkg::SCORE_W,
  parameter int unsigned NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int unsigned ACC_W       = 36
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  input  logic                           Start,
  input  logic                           InValid,
  output logic                           InReady,
  input  logic [ACT_W-1:0]               Activation,
  input  logic [NUM_CLASSES*WGT_W-1:0]   Weights,
  input  logic [NUM_CLASSES*SCORE_W-1:0] Biases,
  output logic [NUM_CLASSES*SCORE_W-1:0] Num,
  output logic                           NumValid,
  output logic                           Busy
);

  import nn_pkg::*;

  localparam int unsigned CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

  state_e                         state_d, state_q;
  logic [CNT_W-1:0]               count_d, count_q;
  logic [NUM_CLASSES*SCORE_W-1:0] num_d, num_q;
  logic                           num_valid_d, num_valid_q;
  logic [NUM_CLASSES*SCORE_W-1:0] lane_scores;
  logic                           lane_clear;
  logic                           beat;
  logic                           bias_en;

  assign lane_clear = (state_q == IDLE) && Start;
  assign beat       = (state_q == ACCUM) && InValid;
  assign bias_en    = (state_q == BIAS);

  assign InReady  = (state_q == ACCUM);
  assign Busy     = (state_q != IDLE);
  assign Num      = num_q;
  assign NumValid = num_valid_q;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    mac_lane #(
      .ACT_W   (ACT_W),
      .WGT_W   (WGT_W),
      .SCORE_W (SCORE_W),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (GlobalReset),
      .clear   (lane_clear),
      .en_mul  (beat),
      .en_bias (bias_en),
      .a       (Activation),
      .w       (Weights[k*WGT_W +: WGT_W]),
      .b       (Biases[k*SCORE_W +: SCORE_W]),
      .score   (lane_scores[k*SCORE_W +: SCORE_W])
    );
  end

  // Sequencing: accept NUM_INPUTS beats, add biases, then publish saturated scores
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    num_d       = num_q;
    num_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = ACCUM;
          count_d = '0;
        end
      end
      ACCUM: begin
        if (beat) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST_IDX) begin
            state_d = BIAS;
          end
        end
      end
      BIAS: begin
        state_d = DONE;
      end
      DONE: begin
        num_d       = lane_scores;
        num_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
    end
  end

endmodule

// File: tb/tb_output_score_accumulator.sv
// Directed bench for output_score_accumulator with NUM_INPUTS=4.
module tb_output_score_accumulator;

  localparam int NV = 8;

  logic         clk;
  logic         GlobalReset;
  logic         Start;
  logic         InValid;
  logic         InReady;
  logic [12:0]  Activation;
  logic [129:0] Weights;
  logic [259:0] Biases;
  logic [259:0] Num;
  logic         NumValid;
  logic         Busy;

  int total;
  int bad;

  typedef struct packed {
    logic [3:0][12:0] act;
    logic [9:0][12:0] wgt;
    logic [9:0][25:0] bias;
    logic [9:0][25:0] expv;
    logic             stall;
    logic             misuse;
  } vec_t;

  vec_t vecs [NV];

  output_score_accumulator #(
    .NUM_INPUTS (4)
  ) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .Start       (Start),
    .InValid     (InValid),
    .InReady     (InReady),
    .Activation  (Activation),
    .Weights     (Weights),
    .Biases      (Biases),
    .Num         (Num),
    .NumValid    (NumValid),
    .Busy        (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Start pulse with a stray InValid beat that must not be taken in IDLE
  task automatic start_inference(input vec_t v, input int tag);
    Start      = 1'b1;
    InValid    = 1'b1;
    Activation = 13'd50;
    Weights    = v.wgt;
    check($sformatf("v%0d idle_inready", tag), 64'(InReady), 64'd0);
    @(negedge clk);
    Start   = 1'b0;
    InValid = 1'b0;
    check($sformatf("v%0d busy_after_start", tag), 64'(Busy), 64'd1);
  endtask

  task automatic drive_beat(input logic [12:0] a, input logic [129:0] w, input int tag);
    Activation = a;
    Weights    = w;
    InValid    = 1'b1;
    check($sformatf("v%0d accum_inready", tag), 64'(InReady), 64'd1);
    @(negedge clk);
    InValid    = 1'b0;
    Activation = 13'h0AA;
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    Biases = v.bias;
    start_inference(v, tag);
    for (int b = 0; b < 4; b++) begin
      if (v.stall && b > 0) begin
        repeat (2) @(negedge clk);
      end
      if (v.misuse && b == 2) begin
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
      end
      drive_beat(v.act[b], v.wgt, tag);
    end
    // one edge after the last beat: BIAS
    check($sformatf("v%0d bias_valid", tag), 64'(NumValid), 64'd0);
    check($sformatf("v%0d bias_inready", tag), 64'(InReady), 64'd0);
    @(negedge clk);
    // two edges: DONE, result registered on the next edge
    check($sformatf("v%0d done_valid", tag), 64'(NumValid), 64'd0);
    check($sformatf("v%0d done_inready", tag), 64'(InReady), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d numvalid", tag), 64'(NumValid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("v%0d num[%0d]", tag, k), 64'(Num[k*26 +: 26]), 64'(v.expv[k]));
    end
    @(negedge clk);
    check($sformatf("v%0d numvalid_drop", tag), 64'(NumValid), 64'd0);
    check($sformatf("v%0d busy_end", tag), 64'(Busy), 64'd0);
    check($sformatf("v%0d num_hold", tag), 64'(Num[25:0]), 64'(v.expv[0]));
  endtask

  initial begin
    int amax;
    logic signed [25:0] best;
    logic signed [25:0] cur;

    total = 0;
    bad   = 0;

    for (int i = 0; i < NV; i++) vecs[i] = '0;
    // 0: basic, Num[k] = 10k
    for (int b = 0; b < 4; b++) vecs[0].act[b] = 13'(b + 1);
    for (int k = 0; k < 10; k++) begin
      vecs[0].wgt[k]  = 13'(k);
      vecs[0].expv[k] = 26'(10 * k);
    end
    // 1: class 3 weight -5, activations 7, bias 100 -> -40
    for (int b = 0; b < 4; b++) vecs[1].act[b] = 13'd7;
    vecs[1].wgt[3]  = 13'h1FFB;
    vecs[1].bias[3] = 26'd100;
    vecs[1].expv[3] = 26'h3FFFFD8;
    // 2: positive saturation, 4*4095*4095 = 67076100
    // 3: negative saturation, 4*4095*-4096 = -67092480
    for (int b = 0; b < 4; b++) begin
      vecs[2].act[b] = 13'd4095;
      vecs[3].act[b] = 13'd4095;
    end
    for (int k = 0; k < 10; k++) begin
      vecs[2].wgt[k]  = 13'd4095;
      vecs[2].expv[k] = 26'h1FFFFFF;
      vecs[3].wgt[k]  = 13'h1000;
      vecs[3].expv[k] = 26'h2000000;
    end
    // 4: mixed signs, sum(act) = -2, w = k-5, bias = 1000k-3000 -> 998k-2990
    vecs[4].act[0] = 13'd1;
    vecs[4].act[1] = 13'h1FFE;
    vecs[4].act[2] = 13'd3;
    vecs[4].act[3] = 13'h1FFC;
    for (int k = 0; k < 10; k++) begin
      vecs[4].wgt[k]  = 13'(k - 5);
      vecs[4].bias[k] = 26'(1000 * k - 3000);
      vecs[4].expv[k] = 26'(998 * k - 2990);
    end
    // 5: bias at the score limits pushed just past them by +-4
    for (int b = 0; b < 4; b++) vecs[5].act[b] = 13'd1;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        vecs[5].wgt[k]  = 13'd1;
        vecs[5].bias[k] = 26'h1FFFFFF;
        vecs[5].expv[k] = 26'h1FFFFFF;
      end else begin
        vecs[5].wgt[k]  = 13'h1FFF;
        vecs[5].bias[k] = 26'h2000000;
        vecs[5].expv[k] = 26'h2000000;
      end
    end
    // 6: basic with InValid gaps; 7: basic with Start during ACCUM
    vecs[6]       = vecs[0];
    vecs[6].stall = 1'b1;
    vecs[7]        = vecs[0];
    vecs[7].misuse = 1'b1;

    GlobalReset = 1'b0;
    Start       = 1'b0;
    InValid     = 1'b0;
    Activation  = '0;
    Weights     = '0;
    Biases      = '0;
    repeat (2) @(negedge clk);
    check("rst num", 64'(|Num), 64'd0);
    check("rst numvalid", 64'(NumValid), 64'd0);
    check("rst inready", 64'(InReady), 64'd0);
    check("rst busy", 64'(Busy), 64'd0);
    GlobalReset = 1'b1;
    @(negedge clk);
    check("idle inready", 64'(InReady), 64'd0);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
      if (i == 1) begin
        amax = 0;
        best = Num[25:0];
        for (int k = 1; k < 10; k++) begin
          cur = Num[k*26 +: 26];
          if (cur > best) begin
            best = cur;
            amax = k;
          end
        end
        check("v1 argmax", 64'(amax), 64'd0);
      end
    end

    // Abort after two beats: asynchronous clear, then a clean run
    Biases = vecs[4].bias;
    start_inference(vecs[4], 100);
    drive_beat(vecs[4].act[0], vecs[4].wgt, 100);
    drive_beat(vecs[4].act[1], vecs[4].wgt, 100);
    check("pre_abort num nonzero", 64'(|Num), 64'd1);
    #2;
    GlobalReset = 1'b0;
    #1;
    check("abort num", 64'(|Num), 64'd0);
    check("abort numvalid", 64'(NumValid), 64'd0);
    check("abort busy", 64'(Busy), 64'd0);
    check("abort inready", 64'(InReady), 64'd0);
    @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    check("post_abort busy", 64'(Busy), 64'd0);
    run_vec(vecs[0], 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_score_accumulator.md
Name: output_score_accumulator

Overview:
- Final dense layer of the classifier datapath, sitting directly upstream of the max/argmax stage.
- Consumes a serial stream of hidden-layer activations, each paired with the 10 per-class weights for that input.
- Runs 10 parallel signed MACs, adds per-class biases, saturates each result to 26 bits, and presents the packed 260-bit score vector with a one-cycle valid pulse.
- The score vector is the Num input of the argmax stage; class k occupies Num[k*26 +: 26].

Parameters:
- NUM_INPUTS, 64, activations per inference (min 2).
- ACT_W, 13, signed activation width.
- WGT_W, 13, signed weight width.
- SCORE_W, 26, signed output score width per class.
- NUM_CLASSES, 10, number of output classes.
- ACC_W, 36, internal signed accumulator width (ACT_W+WGT_W+clog2(NUM_INPUTS)+headroom).

Ports:
- clk  in  1  system clock, rising edge.
- GlobalReset  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse; begins a new inference.
- InValid  in  1  Activation/Weights beat valid.
- InReady  out  1  block accepts a beat this cycle.
- Activation  in  ACT_W  signed activation for current input index.
- Weights  in  NUM_CLASSES*WGT_W  packed signed weights; class k at [k*WGT_W +: WGT_W].
- Biases  in  NUM_CLASSES*SCORE_W  packed signed biases; held stable during inference, sampled in BIAS state.
- Num  out  NUM_CLASSES*SCORE_W  packed saturated scores, registered.
- NumValid  out  1  one-cycle pulse when Num is updated.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (GlobalReset=0, async): state=IDLE, accumulators=0, count=0, Num=0, NumValid=0, InReady=0, Busy=0.
- FSM states:
  - IDLE: InReady=0. Start=1 → clear all accumulators, count=0, go to ACCUM.
  - ACCUM: InReady=1. On a beat (InValid&InReady), acc[k] += sext(Activation*Weights[k]) for every k, and count++. The beat with count==NUM_INPUTS-1 goes to BIAS. With no beat, hold.
  - BIAS: InReady=0. acc[k] += sext(Biases[k]); go to DONE.
  - DONE: Num[k] = sat(acc[k]); NumValid=1 for this cycle only; go to IDLE.
- Products: full-precision signed ACT_W+WGT_W, sign-extended to ACC_W. No rounding or shifting.
- Saturation: acc > 2^25-1 → 0x1FFFFFF; acc < -2^25 → 0x2000000; otherwise truncate to low 26 bits.
- Accumulator width guarantees no internal wrap for NUM_INPUTS ≤ 1024 at full-scale operands.
- Latency: the beat accepted on edge N produces NumValid and the new Num on edge N+2. Minimum inference time is NUM_INPUTS+3 cycles from Start.
- Num holds its last value until the next DONE. Argmax may sample it any time after NumValid.
- Start while Busy: ignored. No restart, no error flag.
- Start and InValid in the same IDLE cycle: the beat is not accepted (InReady=0), so the first beat is accepted no earlier than the next cycle.
- InValid gaps in ACCUM: allowed, with no limit on stall length.
- Reset mid-inference: immediate abort to the reset state. Partial sums are discarded and NumValid does not fire.

Decomposition:
- Shared package `nn_pkg`:
  - constants NUM_CLASSES=10, SCORE_W=26, ACT_W, WGT_W;
  - localparam SCORE_MAX/SCORE_MIN;
  - state enum {IDLE, ACCUM, BIAS, DONE}.
- The argmax stage uses the same NUM_CLASSES and SCORE_W from this package.
- One sub-module, `mac_lane`, instantiated NUM_CLASSES times. It holds one ACC_W accumulator and takes clear, en_mul, en_bias, a, w and b. Saturation logic lives inside the lane.
- The top holds the FSM, counter and packing.

Test Plan:
- Basic: NUM_INPUTS=4; activations 1,2,3,4; all weights for class k = k; biases 0 → Num[k]=10k; NumValid exactly one cycle, 2 edges after the 4th beat.
- Signed and bias: class 3 weights -5, activations all 7, bias[3]=100; other classes weight 0 and bias 0 → Num[3]=-40 (0x3FFFFD8); other classes 0; argmax index (fed from Num) = 0.
- Saturation: activation 4095, weight 4095, NUM_INPUTS=4, bias 0 → raw 67,076,100 → Num=0x1FFFFFF. Same with weight -4096 → raw -67,092,480 → Num=0x2000000.
- Backpressure/stalls: toggle InValid 1,0,0,1,… across 4 beats → identical Num to the basic test; count advances only on accepted beats; InReady=0 in IDLE, BIAS and DONE.
- Start misuse: a Start pulse during ACCUM after beat 2 → ignored; the result still matches the uninterrupted sum.
- Reset mid-op: assert GlobalReset low after beat 2 → asynchronously Num=0, NumValid=0, Busy=0 without waiting for an edge. After release, a Start and 4 beats give a correct result with no residue from the aborted run.
